router_pkt_fifo: RTL
====================

Name: router_pkt_fifo

Overview:
Parametrised packet-aware synchronous FIFO for the router output channels. It is the next generation of the per-port 8-bit/16-deep FIFO, generalised in data width, depth and header length field. Each stored word carries a header tag. The read side emits registered data plus valid, start-of-packet and end-of-packet qualifiers instead of tri-stating the output. It also reports fill level and almost-full for back-pressure to the router FSM.

Parameters:
DATA_W, 8, data word width in bits (>=4)
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 2**DEPTH_LOG2, default 16)
LEN_MSB, 7, MSB of payload-length field inside a header word
LEN_LSB, 2, LSB of payload-length field inside a header word
AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN

Ports:
clock  in  1  clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
soft_reset  in  1  synchronous flush (timeout from router sync block)
write_en  in  1  write request
lfd_state  in  1  router FSM load-first-data state; tags the word written one cycle later as header
data_in  in  DATA_W  write data
read_en  in  1  read request
data_out  out  DATA_W  registered read data
out_valid  out  1  data_out holds a word popped on the previous cycle
sop_out  out  1  the popped word is a header
eop_out  out  1  the popped word is the last byte of its packet (parity byte)
empty  out  1  no stored words
full  out  1  2**DEPTH_LOG2 stored words
almost_full  out  1  level >= depth - AF_MARGIN
level  out  DEPTH_LOG2+1  number of stored words
ovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset is resetn, synchronous and active-low, on clock. It has priority over soft_reset. soft_reset has priority over read and write.
- Reset and soft_reset clear the pointers, level, packet counter, the delayed lfd flag, data_out=0, out_valid=0, sop_out=0, eop_out=0 and ovf=0. Memory contents are not cleared. After either: empty=1, full=0, almost_full=0 (AF_MARGIN < depth).
- Storage: 2**DEPTH_LOG2 entries of DATA_W+1 bits. The extra bit is the header tag.
- Pointers are DEPTH_LOG2+1 bits with a wrap bit. empty = (rd_ptr == wr_ptr). full = (MSBs differ and the remaining bits are equal). Both are combinational from registered state.
- The lfd_state input is registered once internally (lfd_d). A write accepted while lfd_d=1 stores tag=1; otherwise it stores tag=0.
- Write is accepted when write_en && !full. A write while full is dropped, and the pointer and level are unchanged.
- Read is accepted when read_en && !empty. On the next cycle: data_out = word, out_valid=1, sop_out = tag. On cycles with no accepted read: out_valid=0, sop_out=0, eop_out=0, and data_out holds its last value (never Z).
- Simultaneous accepted read and write: both pointers advance and level is unchanged. A read and write at full: the write is rejected because full is evaluated before the read, and level decrements by 1. A read and write at empty: only the write is accepted.
- level: +1 on an accepted write only, -1 on an accepted read only, unchanged otherwise. Width DEPTH_LOG2+1, so it never wraps.
- Packet counter pkt_cnt (LEN_MSB-LEN_LSB+2 bits):
  - Header pop: loads word[LEN_MSB:LEN_LSB]+1 (payload plus parity). eop_out=0.
  - Non-header pop with pkt_cnt==1: eop_out=1 and pkt_cnt goes to 0.
  - Non-header pop with pkt_cnt>1: decrement.
  - Non-header pop with pkt_cnt==0 (orphan word): eop_out=0 and pkt_cnt stays 0.
- Header with length 0: the next pop is the parity byte and carries eop_out=1.
- soft_reset mid-packet discards the partial packet. The next tagged write starts a fresh packet.
- Latency: write to empty-deassert is 1 cycle. Accepted read to out_valid is 1 cycle.

Optional Feature:
Macro ROUTER_PKT_FIFO_OVF_EN.
- Defined: ovf sets on any cycle with write_en && full (outside reset and soft_reset). It stays set until resetn or soft_reset.
- Not defined: ovf is tied to 0 and no overflow logic is built. All other behaviour is identical.

Test Plan:
- Defaults; lfd_state pulse then write header 0x14 (len=5), 5 payload bytes, parity byte; then read 7 -> out_valid on 7 cycles, sop_out only on the first (data_out=0x14), eop_out only on the 7th, level returns to 0.
- Write 16 words, then a 17th with a distinct value -> full=1, level=16, almost_full=1 from level 14. Read all 16 -> original order, 17th value absent, ovf=1 when the macro is defined, else 0.
- Hold level at 5; assert read_en and write_en together for 10 cycles -> level stays 5, out_valid=1 every cycle, data in FIFO order.
- Interleave 40 writes and reads at level 1-3 -> pointers wrap twice, no full/empty glitch, data_out sequence matches a scoreboard.
- Mid-packet (header len=10, 4 bytes read) assert soft_reset -> next cycle empty=1, level=0, data_out=0, out_valid=0. A new header 0x08 (len=2) gives eop_out on its 3rd byte.
- With full=1, assert read_en and write_en in the same cycle -> write ignored, level=15, full=0 next cycle.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for the router output channels with SOP/EOP read qualifiers.
// Define ROUTER_PKT_FIFO_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module router_pkt_fifo #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned LEN_MSB    = 7,
   parameter int unsigned LEN_LSB    = 2,
   parameter int unsigned AF_MARGIN  = 2
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  soft_reset,
   input  logic                  write_en,
   input  logic                  lfd_state,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  read_en,
   output logic [DATA_W-1:0]     data_out,
   output logic                  out_valid,
   output logic                  sop_out,
   output logic                  eop_out,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  ovf
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
   localparam int unsigned LenW  = LEN_MSB - LEN_LSB + 1;
   localparam int unsigned CntW  = LenW + 1;

   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic [PtrW-1:0] AfLevel = PtrW'(Depth - AF_MARGIN);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   // Each entry is {header_tag, data}
   logic [DATA_W:0]     mem [Depth];

   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]     level_q, level_d;
   logic [CntW-1:0]     pkt_cnt_q, pkt_cnt_d;
   logic                lfd_q, lfd_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                out_valid_q, out_valid_d;
   logic                sop_q, sop_d;
   logic                eop_q, eop_d;

   logic                wr_acc;
   logic                rd_acc;
   logic [DATA_W:0]     rd_word;
   logic [LenW-1:0]     hdr_len;

   assign empty = (rd_ptr_q == wr_ptr_q);
   assign full  = (rd_ptr_q[PtrW-1] != wr_ptr_q[PtrW-1]) &&
                  (rd_ptr_q[PtrW-2:0] == wr_ptr_q[PtrW-2:0]);

   // Both accepts use pre-edge flags, so a write at full is rejected even with a read
   assign wr_acc = write_en && !full;
   assign rd_acc = read_en && !empty;

   assign rd_word = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
   assign hdr_len = rd_word[LEN_MSB:LEN_LSB];

   assign almost_full = (level_q >= AfLevel);
   assign level       = level_q;
   assign data_out    = data_out_q;
   assign out_valid   = out_valid_q;
   assign sop_out     = sop_q;
   assign eop_out     = eop_q;

   always_ff @(posedge clock) begin
      if (resetn && !soft_reset && wr_acc) begin
         mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {lfd_q, data_in};
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      pkt_cnt_d   = pkt_cnt_q;
      lfd_d       = lfd_state;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      sop_d       = 1'b0;
      eop_d       = 1'b0;

      if (soft_reset) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         pkt_cnt_d  = '0;
         lfd_d      = 1'b0;
         data_out_d = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
         end

         if (rd_acc) begin
            rd_ptr_d    = rd_ptr_q + PtrOne;
            data_out_d  = rd_word[DATA_W-1:0];
            out_valid_d = 1'b1;
            sop_d       = rd_word[DATA_W];
            // Header loads payload length plus one for the trailing parity byte
            if (rd_word[DATA_W]) begin
               pkt_cnt_d = CntW'(hdr_len) + CntOne;
            end else if (pkt_cnt_q == CntOne) begin
               eop_d     = 1'b1;
               pkt_cnt_d = '0;
            end else if (pkt_cnt_q != '0) begin
               pkt_cnt_d = pkt_cnt_q - CntOne;
            end
         end

         unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + PtrOne;
            2'b01:   level_d = level_q - PtrOne;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         pkt_cnt_q   <= '0;
         lfd_q       <= 1'b0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         pkt_cnt_q   <= pkt_cnt_d;
         lfd_q       <= lfd_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
      end
   end

`ifdef ROUTER_PKT_FIFO_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (soft_reset) begin
         ovf_d = 1'b0;
      end else if (write_en && full) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule
